// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter and sequencer sharing one SPI master among NUM_REQ requesters
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a stuck transaction after TIMEOUT_CYCLES clocks.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PACK_LENGTH    = 8,
  parameter int LAUNCH_HOLD    = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           IN_CLOCK,
  input  logic                           IN_RESET_N,
  input  logic [NUM_REQ-1:0]             IN_REQ,
  input  logic [NUM_REQ*PACK_LENGTH-1:0] IN_REQ_DATA,
  output logic [NUM_REQ-1:0]             OUT_GRANT,
  output logic [NUM_REQ-1:0]             OUT_RESP_VALID,
  output logic [PACK_LENGTH-1:0]         OUT_RESP_DATA,
  output logic                           OUT_BUSY,
  output logic                           OUT_TIMEOUT_ERR,
  output logic                           OUT_SPI_LAUNCH,
  output logic [PACK_LENGTH-1:0]         OUT_SPI_TX_DATA,
  input  logic                           IN_SPI_CS,
  input  logic                           IN_SPI_DONE,
  input  logic [PACK_LENGTH-1:0]         IN_SPI_RX_DATA
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || LAUNCH_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_master_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_HOLD, S_WAIT_DONE, S_RESP} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       ptr, idx, win_idx;
  logic                   win_found;
  logic                   done_q, done_edge, sticky;
  logic [15:0]            hold_cnt;
  logic                   timeout_hit, timeout_flag;
  logic [PACK_LENGTH-1:0] tx_data, resp_data;
  logic [NUM_REQ-1:0]     idx_onehot;

  // Add k to a requester index, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Only a rising edge of done counts, so a level left high by the previous pack is ignored.
  assign done_edge  = IN_SPI_DONE & ~done_q;
  assign idx_onehot = NUM_REQ'(1) << idx;

  assign OUT_RESP_DATA   = resp_data;
  assign OUT_SPI_TX_DATA = tx_data;

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && IN_REQ[wrap_add(ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr, k);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Watchdog counts every cycle spent waiting on the master; idle keeps it cleared for the next launch.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= timeout_hit;
      if (state == S_IDLE)
        to_cnt <= '0;
      else if (state == S_LAUNCH || state == S_HOLD || state == S_WAIT_DONE)
        to_cnt <= to_cnt + 32'd1;
    end
  end

  assign timeout_hit = (state == S_LAUNCH || state == S_HOLD || state == S_WAIT_DONE) &&
                       (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) state <= S_IDLE;
    else             state <= state_next;
  end

  // Next-state and state-decoded outputs; all outputs fall to 0 the moment reset forces IDLE.
  always_comb begin
    state_next      = state;
    OUT_GRANT       = '0;
    OUT_RESP_VALID  = '0;
    OUT_BUSY        = 1'b0;
    OUT_SPI_LAUNCH  = 1'b0;
    OUT_TIMEOUT_ERR = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        OUT_GRANT      = idx_onehot;
        OUT_BUSY       = 1'b1;
        OUT_SPI_LAUNCH = 1'b1;
        if (!IN_SPI_CS) state_next = S_HOLD;
      end
      S_HOLD: begin
        OUT_GRANT      = idx_onehot;
        OUT_BUSY       = 1'b1;
        OUT_SPI_LAUNCH = 1'b1;
        if (hold_cnt == 16'(LAUNCH_HOLD - 1)) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        OUT_GRANT = idx_onehot;
        OUT_BUSY  = 1'b1;
        if (done_edge || sticky) state_next = S_RESP;
      end
      S_RESP: begin
        OUT_GRANT       = idx_onehot;
        OUT_BUSY        = 1'b1;
        OUT_RESP_VALID  = idx_onehot;
        OUT_TIMEOUT_ERR = timeout_flag;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) begin
      OUT_SPI_LAUNCH = 1'b0;
      state_next     = S_RESP;
    end
  end

  // Datapath: winner capture, hold timing, early-done memory, response capture and pointer update.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      done_q    <= 1'b0;
      sticky    <= 1'b0;
      hold_cnt  <= '0;
      idx       <= '0;
      ptr       <= '0;
      tx_data   <= '0;
      resp_data <= '0;
    end else begin
      done_q <= IN_SPI_DONE;
      case (state)
        S_IDLE: begin
          sticky <= 1'b0;
          if (win_found) begin
            idx     <= win_idx;
            tx_data <= IN_REQ_DATA[win_idx*PACK_LENGTH +: PACK_LENGTH];
          end
        end
        S_LAUNCH: begin
          hold_cnt <= '0;
          if (done_edge) sticky <= 1'b1;
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + 16'd1;
          if (done_edge) sticky <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (done_edge || sticky) begin
            sticky    <= 1'b0;
            resp_data <= IN_SPI_RX_DATA;
          end
        end
        S_RESP: begin
          ptr <= wrap_add(idx, 1);
        end
        default: ;
      endcase
      if (timeout_hit) begin
        sticky    <= 1'b0;
        resp_data <= '0;
      end
    end
  end

endmodule
